// File: rtl/can_pkg.sv
// Shared widths, type aliases and FSM encoding for the CAN transmit scheduler.
package can_pkg;

   localparam int ID_W   = 11;
   localparam int DATA_W = 32;

   typedef logic [ID_W-1:0]   can_id_t;
   typedef logic [DATA_W-1:0] can_data_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SELECT = 2'd1;
   localparam logic [1:0] ST_LAUNCH = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

endpackage

// File: rtl/can_mb_select.sv
// Combinational pick of the pending mailbox with the lowest CAN ID.
module can_mb_select
   import can_pkg::*;
#(
   parameter int NUM_MB = 4
) (
   input  logic [NUM_MB-1:0]          pending,
   input  can_id_t [NUM_MB-1:0]       ids,
   output logic                       valid,
   output logic [$clog2(NUM_MB)-1:0]  index
);

   localparam int IDX_W = $clog2(NUM_MB);

   can_id_t best;

   // Strict less-than keeps the earlier (lower) index when IDs tie.
   always_comb begin
      valid = 1'b0;
      index = '0;
      best  = '1;
      for (int i = 0; i < NUM_MB; i++) begin
         if (pending[i] && (!valid || (ids[i] < best))) begin
            valid = 1'b1;
            index = i[IDX_W-1:0];
            best  = ids[i];
         end
      end
   end

endmodule

// File: rtl/can_tx_scheduler.sv
// Mailbox-based CAN transmit scheduler: lowest-ID arbitration, retry limit, abort.
module can_tx_scheduler
   import can_pkg::*;
#(
   parameter int NUM_MB    = 4,
   parameter int MAX_RETRY = 8
) (
   input  logic                       clk,
   input  logic                       RESET,
   input  logic                       wr_en,
   input  logic [$clog2(NUM_MB)-1:0]  wr_mb,
   input  logic [ID_W-1:0]            wr_id,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       abort_en,
   input  logic [$clog2(NUM_MB)-1:0]  abort_mb,
   output logic                       tx_send,
   output logic [ID_W-1:0]            tx_id,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_done,
   input  logic                       tx_arb_lost,
   input  logic                       tx_error,
   output logic [NUM_MB-1:0]          pending,
   output logic [NUM_MB-1:0]          done_pulse,
   output logic [NUM_MB-1:0]          fail_pulse,
   output logic                       wr_reject,
   output logic                       busy
);

   localparam int         IDX_W   = $clog2(NUM_MB);
   localparam logic [3:0] MAX_CNT = 4'(MAX_RETRY);

   logic [1:0]              state;
   can_id_t   [NUM_MB-1:0]  mb_id;
   can_data_t [NUM_MB-1:0]  mb_data;
   logic [NUM_MB-1:0][3:0]  retry_cnt;
   logic [IDX_W-1:0]        active_mb;
   logic                    abort_flag;

   logic                    sel_valid;
   logic [IDX_W-1:0]        sel_idx;
   logic [IDX_W-1:0]        cur_mb;
   logic                    have_active;
   logic                    wr_hits_active;
   logic                    wr_abort_clash;
   logic                    abort_hits_active;
   logic                    outcome_abort;
   logic [3:0]              next_retry;

   can_mb_select #(.NUM_MB(NUM_MB)) u_select (
      .pending (pending),
      .ids     (mb_id),
      .valid   (sel_valid),
      .index   (sel_idx)
   );

   // In SELECT the mailbox being latched this cycle already counts as active.
   always_comb begin
      cur_mb            = (state == ST_SELECT) ? sel_idx : active_mb;
      have_active       = (state == ST_SELECT) ? sel_valid : (state != ST_IDLE);
      wr_abort_clash    = wr_en && abort_en && (wr_mb == abort_mb);
      wr_hits_active    = wr_en && have_active && (wr_mb == cur_mb);
      abort_hits_active = abort_en && have_active && (abort_mb == cur_mb);
      outcome_abort     = abort_flag || abort_hits_active;
      next_retry        = retry_cnt[active_mb] + 4'd1;
   end

   assign tx_send = (state == ST_LAUNCH);
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state      <= ST_IDLE;
         pending    <= '0;
         retry_cnt  <= '0;
         abort_flag <= 1'b0;
         mb_id      <= '0;
         mb_data    <= '0;
         active_mb  <= '0;
         tx_id      <= '0;
         tx_data    <= '0;
         done_pulse <= '0;
         fail_pulse <= '0;
         wr_reject  <= 1'b0;
      end else begin
         done_pulse <= '0;
         fail_pulse <= '0;
         wr_reject  <= wr_hits_active || wr_abort_clash;

         if (wr_en && !wr_hits_active && !wr_abort_clash) begin
            mb_id[wr_mb]     <= wr_id;
            mb_data[wr_mb]   <= wr_data;
            pending[wr_mb]   <= 1'b1;
            retry_cnt[wr_mb] <= 4'd0;
         end

         // An abort of the in-flight frame is deferred until can_tx reports back.
         if (abort_en) begin
            if (abort_hits_active) begin
               abort_flag <= 1'b1;
            end else begin
               pending[abort_mb] <= 1'b0;
            end
         end

         case (state)
            ST_IDLE: begin
               if (|pending) begin
                  state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (sel_valid) begin
                  active_mb <= sel_idx;
                  tx_id     <= mb_id[sel_idx];
                  tx_data   <= mb_data[sel_idx];
                  state     <= ST_LAUNCH;
               end else begin
                  abort_flag <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done) begin
                  pending[active_mb]    <= 1'b0;
                  retry_cnt[active_mb]  <= 4'd0;
                  done_pulse[active_mb] <= 1'b1;
                  abort_flag            <= 1'b0;
                  state                 <= ST_IDLE;
               end else if (tx_arb_lost || tx_error) begin
                  abort_flag <= 1'b0;
                  state      <= ST_IDLE;
                  if (outcome_abort || (next_retry == MAX_CNT)) begin
                     pending[active_mb]    <= 1'b0;
                     retry_cnt[active_mb]  <= 4'd0;
                     fail_pulse[active_mb] <= 1'b1;
                  end else begin
                     retry_cnt[active_mb] <= next_retry;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
